// File: rtl/mc_sequencer_if.sv
// ---------------------------------------------------------------------------
// mc_sequencer_if
// Bundle between the multicycle control FSM and the shared ARM/RISC-V
// datapath.
//
// Datapath -> sequencer:
//   arm        ISA mode (1 = ARM, 0 = RISC-V)
//   instr      instruction register contents
//   zero       ALU zero flag
//   condex     ARM condition passed
//   mem_ready  memory completes the current request this cycle
// Sequencer -> datapath:
//   mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
//   resultsrc, alusrca, alusrcb, aluop, immsrc, illegal, instr_done
//
// Modports:
//   master  the sequencer side (drives the control outputs)
//   slave   the datapath side (drives status and instruction)
// ---------------------------------------------------------------------------
interface mc_sequencer_if;
    logic        arm;
    logic [31:0] instr;
    logic        zero;
    logic        condex;
    logic        mem_ready;

    logic        mem_req;
    logic        memwrite;
    logic        adrsrc;
    logic        irwrite;
    logic        pcwrite;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic [1:0]  alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  aluop;
    logic [1:0]  immsrc;
    logic        illegal;
    logic        instr_done;

    modport master (
        input  arm, instr, zero, condex, mem_ready,
        output mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
               resultsrc, alusrca, alusrcb, aluop, immsrc, illegal, instr_done
    );

    modport slave (
        output arm, instr, zero, condex, mem_ready,
        input  mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
               resultsrc, alusrca, alusrcb, aluop, immsrc, illegal, instr_done
    );
endinterface

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
// Multicycle control FSM for the combined ARM/RISC-V core. Steps the shared
// datapath through fetch, decode, execute, memory and writeback, selects the
// immediate format per ISA and handles the memory-ready handshake.
//
// Ports:
//   clk    core clock
//   reset  synchronous, active-high; forces FETCH and zeroes all outputs
//   bus    mc_sequencer_if.master (status/instruction in, controls out)
// ---------------------------------------------------------------------------
module mc_sequencer (
    input  logic           clk,
    input  logic           reset,
    mc_sequencer_if.master bus
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_ABRANCH  = 4'd11;

    logic [3:0] r_state;
    logic [3:0] w_next;
    // ISA mode captured in DECODE so later states do not depend on arm.
    logic       r_arm;

    logic [6:0] w_op;
    logic       w_rv_load;
    logic       w_load;

    logic       w_mem_req, w_memwrite, w_adrsrc, w_irwrite, w_pcwrite;
    logic       w_regwrite, w_illegal, w_done;
    logic [1:0] w_resultsrc, w_alusrca, w_alusrcb, w_aluop, w_immsrc;

    // Instruction bits that this block never looks at (link bit included).
    logic       w_unused;
    assign w_unused = ^{bus.instr[31:28], bus.instr[24:21], bus.instr[19:7]};

    assign w_op      = bus.instr[6:0];
    assign w_rv_load = (w_op == 7'b0000011);
    assign w_load    = r_arm ? bus.instr[20] : w_rv_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_arm <= bus.arm;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_memwrite  = 1'b0;
        w_adrsrc    = 1'b0;
        w_irwrite   = 1'b0;
        w_pcwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_illegal   = 1'b0;
        w_done      = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = 2'b00;
        w_immsrc    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                // IR load and PC+4 only commit on the completing cycle.
                if (bus.mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                w_immsrc  = 2'b10;
                w_next    = S_FETCH;
                if (bus.arm) begin
                    if (!bus.condex) begin
                        w_done = 1'b1;
                    end else begin
                        case (bus.instr[27:26])
                            2'b01:   w_next = S_MEMADR;
                            2'b00:   w_next = bus.instr[25] ? S_EXECI : S_EXECR;
                            2'b10:   w_next = S_ABRANCH;
                            default: begin
                                w_illegal = 1'b1;
                                w_done    = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    case (w_op)
                        7'b0000011, 7'b0100011: w_next = S_MEMADR;
                        7'b0110011:             w_next = S_EXECR;
                        7'b0010011:             w_next = S_EXECI;
                        7'b1100011:             w_next = S_BEQ;
                        7'b1101111:             w_next = S_JAL;
                        default: begin
                            w_illegal = 1'b1;
                            w_done    = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                // RISC-V loads use the I format; stores and all ARM memory ops use 01.
                w_immsrc  = (r_arm || !w_rv_load) ? 2'b01 : 2'b00;
                w_next    = w_load ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adrsrc  = 1'b1;
                if (bus.mem_ready)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                w_adrsrc   = 1'b1;
                w_done     = bus.mem_ready;
                if (bus.mem_ready)
                    w_next = S_FETCH;
            end
            S_EXECR: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_pcwrite = bus.zero;
                w_done    = 1'b1;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                w_alusrca  = 2'b01;
                w_alusrcb  = 2'b10;
                w_pcwrite  = 1'b1;
                w_regwrite = 1'b1;
                w_immsrc   = 2'b11;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_ABRANCH: begin
                w_alusrca   = 2'b01;
                w_alusrcb   = 2'b01;
                w_immsrc    = 2'b10;
                w_resultsrc = 2'b10;
                w_pcwrite   = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Outputs are held at zero for as long as reset is asserted, which also
    // stops any in-flight write the moment reset arrives.
    assign bus.mem_req    = reset ? 1'b0  : w_mem_req;
    assign bus.memwrite   = reset ? 1'b0  : w_memwrite;
    assign bus.adrsrc     = reset ? 1'b0  : w_adrsrc;
    assign bus.irwrite    = reset ? 1'b0  : w_irwrite;
    assign bus.pcwrite    = reset ? 1'b0  : w_pcwrite;
    assign bus.regwrite   = reset ? 1'b0  : w_regwrite;
    assign bus.resultsrc  = reset ? 2'b00 : w_resultsrc;
    assign bus.alusrca    = reset ? 2'b00 : w_alusrca;
    assign bus.alusrcb    = reset ? 2'b00 : w_alusrcb;
    assign bus.aluop      = reset ? 2'b00 : w_aluop;
    assign bus.immsrc     = reset ? 2'b00 : w_immsrc;
    assign bus.illegal    = reset ? 1'b0  : w_illegal;
    assign bus.instr_done = reset ? 1'b0  : w_done;

endmodule
